// File: rtl/accel_feeder.sv
// accel_feeder
// Host-side job source for the accelerator wrapper's drdy/dacc/free handshake.
// The host writes NWORDS words into a local buffer. When the buffer is full
// and the wrapper is free, the words are streamed out on dout. Each word is
// paced by dacc, then a one-cycle drdy trigger pulse follows. The block then
// waits for the wrapper to go busy and come back to free before taking the
// next job.
//
// Handshake: during XFER drdy is held high. A word is consumed on every
// rising edge where dacc=1, and dout then moves on to the next word. dacc
// seen while drdy=0 is ignored. There is no combinational path from dacc or
// free to any output.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset (aborts any job in flight)
//   wr_en     host write strobe, one buffer word per cycle
//   wr_data   host write data
//   full      buffer holds NWORDS words; the host must stop writing
//   free      wrapper idle indication (combinational in the wrapper)
//   dacc      wrapper accepts the word on dout this cycle
//   drdy      data-ready during XFER, trigger strobe during TRIG
//   dout      current data word (meaningful only in XFER)
//   busy      a job is in flight (any state other than FILL)
//   job_done  one-cycle pulse when the wrapper returns to free after a run
//   ovf       sticky: a write was attempted while full or busy
//   dbg_state current FSM state, for checkers and waveform debug
module accel_feeder #(
  parameter int DW     = 8,
  parameter int NWORDS = 8,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          free,
  input  logic          dacc,
  output logic          drdy,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          job_done,
  output logic          ovf,
  output logic [2:0]    dbg_state
);

  // Buffer address width. NWORDS=1 still gets a one-bit address.
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] NW_C   = CW'(NWORDS);
  localparam logic [CW-1:0] LAST_C = CW'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_FILL = 3'd0,
    S_XFER = 3'd1,
    S_GAP  = 3'd2,
    S_TRIG = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] idx;
  logic [CW-1:0] idx_inc;
  logic          seen_busy;
  logic [DW-1:0] dout_q;
  logic          job_done_q;
  logic          ovf_q;
  logic          full_i;
  logic          do_write;
  logic          accept;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  assign full_i   = (wcnt == NW_C);
  assign do_write = (state == S_FILL) && wr_en && !full_i;
  assign accept   = (state == S_XFER) && dacc;
  assign idx_inc  = idx + CW'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FILL;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_FILL: if (full_i && free)              state_nx = S_XFER;
      S_XFER: if (dacc && (idx == LAST_C))     state_nx = S_GAP;
      S_GAP:                                   state_nx = S_TRIG;
      S_TRIG:                                  state_nx = S_WAIT;
      S_WAIT: if (seen_busy && free)           state_nx = S_FILL;
      default:                                 state_nx = S_FILL;
    endcase
  end

  // Counters, flags and the registered data word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt       <= '0;
      idx        <= '0;
      seen_busy  <= 1'b0;
      dout_q     <= '0;
      job_done_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      job_done_q <= (state == S_WAIT) && seen_busy && free;
      if (wr_en && ((state != S_FILL) || full_i)) ovf_q <= 1'b1;

      if (do_write) wcnt <= wcnt + CW'(1);
      if ((state == S_WAIT) && seen_busy && free) wcnt <= '0;

      // dout is preloaded with word 0 on entry to XFER. It then advances one
      // word per acceptance, so the wrapper always sees buf[idx]. After the
      // last word it keeps its value.
      if ((state == S_FILL) && full_i && free) begin
        idx    <= '0;
        dout_q <= mem[0];
      end else if (accept && (idx != LAST_C)) begin
        idx    <= idx_inc;
        dout_q <= mem[idx_inc[AW-1:0]];
      end

      // The run only counts as finished once free has been seen low after
      // the trigger. A free that stays high is not a completion.
      if (state == S_TRIG)                seen_busy <= 1'b0;
      else if ((state == S_WAIT) && !free) seen_busy <= 1'b1;
    end
  end

  // Buffer RAM, intentionally not reset
  always_ff @(posedge clk) begin
    if (do_write) mem[wcnt[AW-1:0]] <= wr_data;
  end

  assign full      = full_i;
  assign drdy      = (state == S_XFER) || (state == S_TRIG);
  assign busy      = (state != S_FILL);
  assign dout      = dout_q;
  assign job_done  = job_done_q;
  assign ovf       = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_accel_feeder.sv
// Testbench for accel_feeder. A behavioural wrapper model consumes the
// stream and checks the words against the queue of words the host wrote.
module tb_accel_feeder;

  localparam int DW = 8;
  localparam int NW = 8;

  // Wrapper model phases
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DATA = 2;
  localparam int M_GAP  = 3;
  localparam int M_TRIG = 4;
  localparam int M_RUN  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          free = 1'b1;
  logic          dacc = 1'b0;
  logic          full, drdy, busy, job_done, ovf;
  logic [DW-1:0] dout;
  logic [2:0]    dbg_state;

  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model controls, written by the main process just after a posedge
  bit force_low = 0;   // hold free low while idle
  bit hold_mode = 0;   // never go busy after trigger
  int bubble_at = -1;  // number of accepted words before the stall
  int bubbles_left = 0;
  int m = M_IDLE;
  int acc_cnt = 0;
  int run_cnt = 0;
  int done_seen = 0;
  int jobs_exp = 0;

  accel_feeder #(.DW(DW), .NWORDS(NW), .CW(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .free(free), .dacc(dacc), .drdy(drdy), .dout(dout), .busy(busy),
    .job_done(job_done), .ovf(ovf), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [DW-1:0] d, input bit accepted);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    if (accepted) exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_bubbles(input int at, input int n);
    @(posedge clk); #1;
    bubble_at = at;
    bubbles_left = n;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) write_word(DW'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_seen >= target) break;
    end
    repeat (3) @(negedge clk);
    chk("job_done_count", done_seen, target);
    chk("words_left", exp_q.size(), 0);
  endtask

  // ---------------- wrapper model / scoreboard monitor ----------------
  initial begin
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m = M_IDLE;
        dacc = 1'b0;
        free = 1'b1;
      end else begin
        case (m)
          M_IDLE: begin
            dacc = 1'b0;
            if (drdy) begin
              m = M_LOAD;
              acc_cnt = 0;
              free = hold_mode ? 1'b1 : 1'b0;
            end else begin
              free = force_low ? 1'b0 : 1'b1;
            end
          end
          M_LOAD: begin
            chk("load_drdy", drdy, 1);
            dacc = 1'b0;
            m = M_DATA;
          end
          M_DATA: begin
            chk("xfer_drdy", drdy, 1);
            if (acc_cnt == bubble_at && bubbles_left > 0) begin
              dacc = 1'b0;
              bubbles_left--;
              if (exp_q.size() > 0) chk("stall_dout", dout, exp_q[0]);
            end else begin
              dacc = 1'b1;
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_extra_word actual=%0h required=none", dout);
              end else begin
                w = exp_q.pop_front();
                chk("xfer_word", dout, w);
              end
              acc_cnt++;
              if (acc_cnt == NW) m = M_GAP;
            end
          end
          M_GAP: begin
            dacc = 1'b0;
            chk("gap_drdy", drdy, 0);
            m = M_TRIG;
          end
          M_TRIG: begin
            chk("trig_drdy", drdy, 1);
            if (hold_mode) m = M_IDLE;
            else begin
              run_cnt = 3;
              m = M_RUN;
            end
          end
          M_RUN: begin
            free = 1'b0;
            if (run_cnt == 0) begin
              free = 1'b1;
              m = M_IDLE;
            end else run_cnt--;
          end
          default: m = M_IDLE;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst && job_done) done_seen++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] fill_state, wait_state;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_drdy", drdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dout", dout, 0);
    fill_state = dbg_state;
    @(negedge clk);
    rst = 1'b1;

    // Job 1: fixed words 0x11..0x88, wrapper idle
    for (int i = 0; i < NW; i++) begin
      write_word(DW'(8'h11 * (i + 1)), 1'b1);
      if (i == NW - 2) chk("full_before_last", full, 0);
    end
    chk("full_after_last", full, 1);
    chk("drdy_same_cycle", drdy, 0);
    @(negedge clk);
    chk("drdy_next_cycle", drdy, 1);
    chk("busy_in_xfer", busy, 1);
    jobs_exp++;
    wait_done(jobs_exp);
    chk("busy_after_done", busy, 0);
    chk("full_after_done", full, 0);

    // Job 2: same words, three stall cycles after the third word
    set_bubbles(3, 3);
    for (int i = 0; i < NW; i++) write_word(DW'(8'h11 * (i + 1)), 1'b1);
    jobs_exp++;
    wait_done(jobs_exp);
    chk("bubbles_used", bubbles_left, 0);

    // Job 3: fill while the wrapper is not free, then a 9th write
    @(posedge clk); #1;
    force_low = 1;
    bubble_at = -1;
    fill_random();
    chk("full_while_busy_wrapper", full, 1);
    repeat (5) @(negedge clk);
    chk("drdy_held_low", drdy, 0);
    chk("busy_held_low", busy, 0);
    write_word(8'hA5, 1'b0);
    chk("ovf_on_9th", ovf, 1);
    chk("full_after_9th", full, 1);
    @(posedge clk); #1;
    force_low = 0;
    @(negedge clk);
    @(negedge clk);
    chk("drdy_after_free", drdy, 1);
    jobs_exp++;
    wait_done(jobs_exp);
    chk("ovf_sticky", ovf, 1);

    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("ovf_cleared", ovf, 0);
    @(negedge clk);
    rst = 1'b1;

    // Job 4: reset in the middle of XFER
    fill_random();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc_cnt >= 5) break;
    end
    chk("reached_word5", int'(acc_cnt >= 5), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_drdy", drdy, 0);
    chk("arst_busy", busy, 0);
    chk("arst_full", full, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fresh jobs with random stalls
    for (int j = 0; j < 3; j++) begin
      set_bubbles($urandom_range(0, NW - 1), $urandom_range(0, 3));
      fill_random();
      jobs_exp++;
      wait_done(jobs_exp);
    end

    // Job with a wrapper that never leaves free after the trigger
    @(posedge clk); #1;
    hold_mode = 1;
    bubble_at = -1;
    fill_random();
    repeat (60) @(negedge clk);
    chk("hold_no_done", done_seen, jobs_exp);
    chk("hold_busy", busy, 1);
    chk("hold_drdy", drdy, 0);
    chk("hold_words_left", exp_q.size(), 0);
    wait_state = dbg_state;
    chk("hold_state_not_fill", int'(wait_state != fill_state), 1);
    write_word(8'h5A, 1'b0);
    chk("ovf_write_in_wait", ovf, 1);
    chk("hold_busy_after_write", busy, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("hold_rst_ovf", ovf, 0);
    chk("hold_rst_busy", busy, 0);
    hold_mode = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
